// File: rtl/lcd_bus_pkg.sv
// ==== lcd_bus_pkg: shared types and constants for the LCD bus responder (rev 1.0) ====
`default_nettype none

package lcd_bus_pkg;

   typedef enum logic [1:0] {
      INIT8 = 2'd0,
      HI    = 2'd1,
      LO    = 2'd2
   } lcd_state_t;

   localparam logic [7:0] CMD_CLR   = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam logic [7:0] CMD_ENTRY = 8'h04;
   localparam logic [7:0] CMD_DDRAM = 8'h80;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [6:0] LINE0_END  = 7'h27;
   localparam logic [6:0] LINE1_END  = 7'h67;

   localparam logic [7:0] BLANK     = 8'h20;
   localparam int         NUM_CELLS = 32;

   // Visible cells are exactly 0x00-0x0F and 0x40-0x4F: bits [5:4] clear.
   function automatic logic cell_hit(input logic [6:0] addr);
      return (addr[5:4] == 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_ac_next.sv
// ==== lcd_ac_next: DDRAM address counter step with line wrap (rev 1.0) ====
`default_nettype none

module lcd_ac_next import lcd_bus_pkg::*; (
   input  logic [6:0] ac,
   input  logic       id,
   output logic [6:0] ac_next
);

   always_comb begin
      ac_next = ac;
      if (id) begin
         if (ac == LINE0_END)      ac_next = LINE1_BASE;
         else if (ac == LINE1_END) ac_next = LINE0_BASE;
         else                      ac_next = ac + 7'd1;
      end else begin
         if (ac == LINE0_BASE)      ac_next = LINE1_END;
         else if (ac == LINE1_BASE) ac_next = LINE0_END;
         else                       ac_next = ac - 7'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/lcd_bus_responder.sv
// ==== lcd_bus_responder: display-side model of a 4-bit HD44780 bus (rev 1.0) ====
`default_nettype none

module lcd_bus_responder import lcd_bus_pkg::*; #(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sf_e,
   input  logic       e,
   input  logic       rs,
   input  logic       rw,
   input  logic [3:0] nibble,
   output logic [3:0] nibble_out,
   output logic       nibble_oe,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic       byte_rs,
   output logic       busy,
   output logic       err_busy
);

   localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   lcd_state_t    state, state_next;
   logic          e_q, sf_e_q, rs_q, rw_q;
   logic [3:0]    nibble_q, hi_q;
   logic [6:0]    ac, ac_step;
   logic          id;
   logic [CW-1:0] busy_cnt;
   logic [7:0]    cells [NUM_CELLS];
   logic          strobe, exec;
   logic [7:0]    exec_byte;
   logic          is_clear, is_home, is_entry, is_ddram, long_busy;

   assign strobe    = e_q & ~e & sf_e_q;
   assign busy      = (busy_cnt != '0);
   assign nibble_oe = e & rw & sf_e;

   assign is_clear  = ~rs_q & (exec_byte == CMD_CLR);
   assign is_home   = ~rs_q & (exec_byte[7:1] == CMD_HOME[7:1]);
   assign is_entry  = ~rs_q & (exec_byte[7:2] == CMD_ENTRY[7:2]);
   assign is_ddram  = ~rs_q & (exec_byte[7] == CMD_DDRAM[7]);
   assign long_busy = is_clear | is_home;

   lcd_ac_next u_ac_next (
      .ac      (ac),
      .id      (id),
      .ac_next (ac_step)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= INIT8;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (strobe) begin
         case (state)
            INIT8:   if (!rw_q && !rs_q && nibble_q == 4'h2) state_next = HI;
            HI:      state_next = LO;
            LO:      state_next = HI;
            default: state_next = INIT8;
         endcase
      end
   end

   // INIT8 writes execute as whole bytes; in nibble mode only the low half executes.
   always_comb begin
      exec       = 1'b0;
      exec_byte  = {nibble_q, 4'h0};
      nibble_out = 4'h0;
      if (state == LO) exec_byte = {hi_q, nibble_q};
      if (state != HI) exec = strobe & ~rw_q;
      if (!rs) nibble_out = (state == LO) ? ac[3:0] : {busy, ac[6:4]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_q        <= 1'b0;
         sf_e_q     <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         nibble_q   <= 4'h0;
         hi_q       <= 4'h0;
         ac         <= LINE0_BASE;
         id         <= 1'b1;
         busy_cnt   <= '0;
         err_busy   <= 1'b0;
         byte_valid <= 1'b0;
         byte_out   <= 8'h00;
         byte_rs    <= 1'b0;
      end else begin
         e_q        <= e;
         sf_e_q     <= sf_e;
         byte_valid <= exec;
         if (e) begin
            rs_q     <= rs;
            rw_q     <= rw;
            nibble_q <= nibble;
         end
         if (strobe && state == HI && !rw_q) hi_q <= nibble_q;
         if (strobe && busy) err_busy <= 1'b1;
         if (exec) begin
            byte_out <= exec_byte;
            byte_rs  <= rs_q;
            busy_cnt <= long_busy ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
            if (rs_q) begin
               ac <= ac_step;
            end else if (is_clear) begin
               ac <= LINE0_BASE;
               id <= 1'b1;
            end else if (is_home) begin
               ac <= LINE0_BASE;
            end else if (is_entry) begin
               id <= exec_byte[1];
            end else if (is_ddram) begin
               ac <= exec_byte[6:0];
            end
         end else if (busy) begin
            busy_cnt <= busy_cnt - CW'(1);
         end
      end
   end

   // Clear blanks the whole array in the same edge that executes it.
   always_ff @(posedge clk) begin
      if (!rst_n || (exec && is_clear)) begin
         for (int i = 0; i < NUM_CELLS; i++) cells[i] <= BLANK;
      end else if (exec && rs_q && cell_hit(ac)) begin
         cells[{ac[6], ac[3:0]}] <= exec_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rd_char <= 8'h00;
      else        rd_char <= cells[rd_addr];
   end

endmodule

`default_nettype wire
